// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// The fetch stage drives requests (master); memory answers in order, one word per accepted request.
interface if_fetch_stage_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues sequential fetches, tags responses with their PC,
// queues them in order for decode and discards responses from redirected-away paths.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               pc_next,
  input  logic                      pcsrc,
  output logic [31:0]               pc,
  if_fetch_stage_if.master          imem,
  output logic                      if_valid,
  output logic [31:0]               if_instr,
  output logic [31:0]               if_pc,
  input  logic                      if_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;

  logic [31:0] tag_q       [DEPTH];
  logic [31:0] buf_pc_q    [DEPTH];
  logic [31:0] buf_instr_q [DEPTH];

  logic        pop, credit, accept, rsp, keep;
  logic [CW:0] occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign if_valid = (buf_cnt_q != '0);
  assign if_pc    = if_valid ? buf_pc_q[buf_rd_q]    : '0;
  assign if_instr = if_valid ? buf_instr_q[buf_rd_q] : '0;
  assign pop      = if_valid & if_ready;

  // A slot freed by this cycle's pop may be reused by this cycle's request.
  assign occupancy = {1'b0, out_cnt_q} + {1'b0, buf_cnt_q} - {{CW{1'b0}}, pop};
  assign credit    = (occupancy < (CW + 1)'(DEPTH));

  // Reset gating keeps the request quiet while rst_n is held low.
  assign imem.imem_req_valid = rst_n & credit & ~pcsrc;
  assign imem.imem_req_addr  = pc_q;
  assign pc                  = pc_q;

  assign accept = imem.imem_req_valid & imem.imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp    = imem.imem_rsp_valid & (out_cnt_q != '0);
  assign keep   = rsp & (drop_cnt_q == '0) & ~pcsrc;

  always_comb begin
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q;
    buf_cnt_d  = buf_cnt_q;
    drop_cnt_d = drop_cnt_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = rsp ? ptr_inc(tag_rd_q) : tag_rd_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;

    if (pcsrc) begin
      // Everything still outstanding belongs to the old path and must be dropped on return.
      pc_d       = pc_next;
      buf_cnt_d  = '0;
      buf_wr_d   = '0;
      buf_rd_d   = '0;
      out_cnt_d  = out_cnt_q - CW'(rsp);
      drop_cnt_d = out_cnt_q - CW'(rsp);
    end else begin
      if (accept) begin
        pc_d     = pc_q + 32'd4;
        tag_wr_d = ptr_inc(tag_wr_q);
      end
      out_cnt_d = out_cnt_q + CW'(accept) - CW'(rsp);
      if (rsp && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
      if (keep) buf_wr_d = ptr_inc(buf_wr_q);
      if (pop)  buf_rd_d = ptr_inc(buf_rd_q);
      buf_cnt_d = buf_cnt_q + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      buf_cnt_q  <= '0;
      drop_cnt_q <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      buf_cnt_q  <= buf_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
    end
  end

  // Storage arrays need no reset; counters decide which entries are live.
  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr_q] <= pc_q;
    if (keep) begin
      buf_pc_q[buf_wr_q]    <= tag_q[tag_rd_q];
      buf_instr_q[buf_wr_q] <= imem.imem_rsp_data;
    end
  end

endmodule
